rnn_concat_buf: RTL and testbench

- Ping-pong vector assembly buffer for the RNN datapath.
- Captures three parallel source vectors (dense output, VAD GRU state, input features) in any order and in any cycles, concatenating them into one frame.
- Streams the frame one float word per cycle to the serial MAC of the next GRU layer, using valid/ready.
- Two banks let frame k+1 fill while frame k drains.

---
 rtl/rnn_pkg.sv | 14 +
 rtl/rnn_concat_bank.sv | 53 +++++
 rtl/rnn_concat_buf.sv | 154 +++++++++++++++
 tb/tb_rnn_concat_buf.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared sizes and bank state encoding for the RNN concat buffer.
package rnn_pkg;
    localparam int FLOAT_W = 32;
    localparam int N_DENSE = 24;
    localparam int N_GRU   = 24;
    localparam int N_FEAT  = 42;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;
endpackage

// File: rtl/rnn_concat_bank.sv
// One frame bank: TOT-word storage, three per-source capture flags and
// an index-addressed combinational read port.
module rnn_concat_bank
    import rnn_pkg::*;
#(
    parameter  int W   = FLOAT_W,
    parameter  int N0  = N_DENSE,
    parameter  int N1  = N_GRU,
    parameter  int N2  = N_FEAT,
    localparam int TOT = N0 + N1 + N2,
    localparam int IW  = $clog2(TOT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic [2:0]    cap_i,
    input  logic [N0*W-1:0] src0_data_i,
    input  logic [N1*W-1:0] src1_data_i,
    input  logic [N2*W-1:0] src2_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [2:0]    flags_o,
    output logic [W-1:0]  rd_data_o
);
    logic [2:0]   flags_q;
    logic [W-1:0] mem_q [TOT];

    // capture flags: cleared on bank free or flush, set per captured source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (clr_i) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_q | cap_i;
        end
    end

    // frame storage, laid out src0 | src1 | src2
    always_ff @(posedge clk) begin
        if (cap_i[0]) begin
            for (int i = 0; i < N0; i++) mem_q[i] <= src0_data_i[i*W +: W];
        end
        if (cap_i[1]) begin
            for (int i = 0; i < N1; i++) mem_q[N0 + i] <= src1_data_i[i*W +: W];
        end
        if (cap_i[2]) begin
            for (int i = 0; i < N2; i++) mem_q[N0 + N1 + i] <= src2_data_i[i*W +: W];
        end
    end

    assign flags_o   = flags_q;
    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/rnn_concat_buf.sv
// Ping-pong concat buffer: fills one bank from three parallel sources while
// the other bank streams out one word per cycle over valid/ready.
module rnn_concat_buf
    import rnn_pkg::*;
#(
    parameter  int W   = FLOAT_W,
    parameter  int N0  = N_DENSE,
    parameter  int N1  = N_GRU,
    parameter  int N2  = N_FEAT,
    localparam int TOT = N0 + N1 + N2,
    localparam int IW  = $clog2(TOT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [N0*W-1:0] src0_data,
    input  logic            src0_valid,
    output logic            src0_ready,
    input  logic [N1*W-1:0] src1_data,
    input  logic            src1_valid,
    output logic            src1_ready,
    input  logic [N2*W-1:0] src2_data,
    input  logic            src2_valid,
    output logic            src2_ready,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     frames_done
);
    bank_state_t   st_q [2];
    bank_state_t   st_d [2];
    logic          fill_sel_q, fill_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   frames_done_q, frames_done_d;

    logic [2:0]    flags_s [2];
    logic [W-1:0]  rd_data_s [2];
    logic [2:0]    fill_flags_s, src_ready_s, cap_s;
    logic          fill_open_s, complete_s, last_s, hs_s, last_hs_s, rd_other_s;

    assign fill_flags_s = flags_s[fill_sel_q];
    assign fill_open_s  = (st_q[fill_sel_q] == EMPTY) || (st_q[fill_sel_q] == FILLING);
    assign src_ready_s  = {3{fill_open_s}} & ~fill_flags_s;
    assign cap_s        = {src2_valid, src1_valid, src0_valid} & src_ready_s & {3{~flush}};
    assign complete_s   = (|cap_s) && (&(fill_flags_s | cap_s));
    assign last_s       = (idx_q == IW'(TOT - 1));
    assign hs_s         = out_valid_q && out_ready;
    assign last_hs_s    = hs_s && last_s;
    assign rd_other_s   = ~rd_sel_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        rnn_concat_bank #(.W(W), .N0(N0), .N1(N1), .N2(N2)) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (flush || (last_hs_s && (rd_sel_q == 1'(b)))),
            .cap_i       (cap_s & {3{fill_sel_q == 1'(b)}}),
            .src0_data_i (src0_data),
            .src1_data_i (src1_data),
            .src2_data_i (src2_data),
            .rd_idx_i    (idx_q),
            .flags_o     (flags_s[b]),
            .rd_data_o   (rd_data_s[b])
        );
    end

    // next-state: capture side, drain side, then drain hand-over
    always_comb begin
        st_d[0]       = st_q[0];
        st_d[1]       = st_q[1];
        fill_sel_d    = fill_sel_q;
        rd_sel_d      = rd_sel_q;
        out_valid_d   = out_valid_q;
        idx_d         = idx_q;
        frames_done_d = frames_done_q;
        if (flush) begin
            st_d[0]     = EMPTY;
            st_d[1]     = EMPTY;
            fill_sel_d  = 1'b0;
            rd_sel_d    = 1'b0;
            out_valid_d = 1'b0;
            idx_d       = '0;
        end else begin
            if (complete_s) begin
                st_d[fill_sel_q] = FULL;
                fill_sel_d       = ~fill_sel_q;
            end else if (|cap_s) begin
                st_d[fill_sel_q] = FILLING;
            end else begin
                st_d[fill_sel_q] = st_q[fill_sel_q];
            end

            if (last_hs_s) begin
                st_d[rd_sel_q] = EMPTY;
                idx_d          = '0;
                frames_done_d  = frames_done_q + 16'd1;
            end else if (hs_s) begin
                idx_d = idx_q + IW'(1);
            end else begin
                idx_d = idx_q;
            end

            // a waiting FULL bank wins over a bank completing this cycle
            if (!out_valid_q || last_hs_s) begin
                if (out_valid_q && (st_q[rd_other_s] == FULL)) begin
                    rd_sel_d           = rd_other_s;
                    st_d[rd_other_s]   = DRAINING;
                    out_valid_d        = 1'b1;
                end else if (complete_s) begin
                    rd_sel_d           = fill_sel_q;
                    st_d[fill_sel_q]   = DRAINING;
                    out_valid_d        = 1'b1;
                end else begin
                    out_valid_d        = 1'b0;
                end
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]       <= EMPTY;
            st_q[1]       <= EMPTY;
            fill_sel_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            idx_q         <= '0;
            frames_done_q <= 16'd0;
        end else begin
            st_q[0]       <= st_d[0];
            st_q[1]       <= st_d[1];
            fill_sel_q    <= fill_sel_d;
            rd_sel_q      <= rd_sel_d;
            out_valid_q   <= out_valid_d;
            idx_q         <= idx_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign src0_ready  = src_ready_s[0];
    assign src1_ready  = src_ready_s[1];
    assign src2_ready  = src_ready_s[2];
    assign out_valid   = out_valid_q;
    assign out_idx     = idx_q;
    assign out_last    = out_valid_q && last_s;
    assign out_data    = out_valid_q ? rd_data_s[rd_sel_q] : {W{1'b0}};
    assign frames_done = frames_done_q;
endmodule

// File: tb/tb_rnn_concat_buf.sv
// Directed bench for rnn_concat_buf: element g of a frame carries base+g.
module tb_rnn_concat_buf;
    localparam int W   = 32;
    localparam int N0  = 24;
    localparam int N1  = 24;
    localparam int N2  = 42;
    localparam int TOT = 90;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N0*W-1:0] src0_data = '0;
    logic [N1*W-1:0] src1_data = '0;
    logic [N2*W-1:0] src2_data = '0;
    logic            src0_valid = 1'b0, src1_valid = 1'b0, src2_valid = 1'b0;
    logic            src0_ready, src1_ready, src2_ready;
    logic [W-1:0]    out_data;
    logic [6:0]      out_idx;
    logic            out_last, out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     frames_done;

    int n_checks = 0;
    int n_fail   = 0;

    rnn_concat_buf dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .src2_data(src2_data), .src2_valid(src2_valid), .src2_ready(src2_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] readies();
        return {src2_ready, src1_ready, src0_ready};
    endfunction

    task automatic present(input int k, input logic [31:0] base);
        if (k == 0) begin
            for (int i = 0; i < N0; i++) src0_data[i*W +: W] = base + 32'(i);
            src0_valid = 1'b1;
        end else if (k == 1) begin
            for (int i = 0; i < N1; i++) src1_data[i*W +: W] = base + 32'(N0 + i);
            src1_valid = 1'b1;
        end else begin
            for (int i = 0; i < N2; i++) src2_data[i*W +: W] = base + 32'(N0 + N1 + i);
            src2_valid = 1'b1;
        end
    endtask

    // advance one cycle; drop each source valid that was accepted on the edge
    task automatic step();
        logic [2:0] p;
        p = {src2_valid, src1_valid, src0_valid} & readies() & {3{~flush}};
        @(negedge clk);
        if (p[0]) src0_valid = 1'b0;
        if (p[1]) src1_valid = 1'b0;
        if (p[2]) src2_valid = 1'b0;
    endtask

    task automatic drain(input logic [31:0] base, input int stall_idx,
                         input int stall_len, input int stop_at);
        int e, stalled, gaps, guard;
        e = 0; stalled = 0; gaps = 0; guard = 0;
        while (e < stop_at && guard < 3000) begin
            guard++;
            if (out_valid) begin
                chk("drain_idx", 32'(out_idx), 32'(e));
                chk("drain_data", out_data, base + 32'(e));
                chk("drain_last", 32'(out_last), 32'(e == TOT - 1));
                if (e == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    e++;
                end
            end else begin
                if (e > 0) gaps++;
                out_ready = 1'b1;
            end
            step();
        end
        chk("drain_count", 32'(e), 32'(stop_at));
        chk("drain_gaps", 32'(gaps), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #23;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_frames", 32'(frames_done), 32'd0);
        chk("rst_ready", 32'(readies()), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // frame A: src2, src0, src1 in separate cycles; stall at idx 30
        present(2, 32'h3F80_0000);
        step();
        chk("a_ready_after_s2", 32'(readies()), 32'd3);
        chk("a_valid_partial", 32'(out_valid), 32'd0);
        present(0, 32'h3F80_0000);
        step();
        chk("a_ready_after_s0", 32'(readies()), 32'd2);
        present(1, 32'h3F80_0000);
        step();
        chk("a_valid_lat1", 32'(out_valid), 32'd1);
        chk("a_data0", out_data, 32'h3F80_0000);
        chk("a_ready_next_bank", 32'(readies()), 32'd7);
        drain(32'h3F80_0000, 30, 10, TOT);
        chk("a_frames", 32'(frames_done), 32'd1);
        chk("a_idle", 32'(out_valid), 32'd0);

        // frames B, C captured under backpressure; D blocked until B frees
        out_ready = 1'b0;
        present(0, 32'h4000_0000); present(1, 32'h4000_0000); present(2, 32'h4000_0000);
        step();
        present(0, 32'h4040_0000); present(1, 32'h4040_0000); present(2, 32'h4040_0000);
        step();
        chk("bc_ready_both_busy", 32'(readies()), 32'd0);
        present(0, 32'h4080_0000); present(1, 32'h4080_0000); present(2, 32'h4080_0000);
        step(); step(); step();
        chk("d_ready_blocked", 32'(readies()), 32'd0);
        chk("d_held", 32'({src2_valid, src1_valid, src0_valid}), 32'd7);
        chk("b_stalled_data", out_data, 32'h4000_0000);
        drain(32'h4000_0000, -1, 0, TOT);
        chk("c_no_bubble", 32'(out_valid), 32'd1);
        chk("bc_frames", 32'(frames_done), 32'd2);
        drain(32'h4040_0000, -1, 0, TOT);
        chk("d_no_bubble", 32'(out_valid), 32'd1);
        drain(32'h4080_0000, -1, 0, TOT);
        chk("d_frames", 32'(frames_done), 32'd4);

        // src0 re-presented with different data is stalled, not overwritten
        present(0, 32'h4100_0000);
        step();
        present(0, 32'h7F00_0000);
        step();
        chk("e_s0_stall", 32'(readies()), 32'd6);
        chk("e_s0_held", 32'(src0_valid), 32'd1);
        present(1, 32'h4100_0000); present(2, 32'h4100_0000);
        step();
        chk("e_valid", 32'(out_valid), 32'd1);
        drain(32'h4100_0000, -1, 0, TOT);
        chk("e_frames", 32'(frames_done), 32'd5);

        // frame X (src0 captured above) flushed at idx 50
        present(1, 32'h7F00_0000); present(2, 32'h7F00_0000);
        step();
        drain(32'h7F00_0000, -1, 0, 50);
        chk("x_at_50", 32'(out_idx), 32'd50);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(readies()), 32'd7);
        chk("flush_idx", 32'(out_idx), 32'd0);
        chk("flush_frames", 32'(frames_done), 32'd5);
        present(0, 32'h4120_0000); present(1, 32'h4120_0000); present(2, 32'h4120_0000);
        step();
        drain(32'h4120_0000, -1, 0, TOT);
        chk("f_frames", 32'(frames_done), 32'd6);

        // async reset mid-drain of G with H partially filled
        present(0, 32'h4200_0000); present(1, 32'h4200_0000); present(2, 32'h4200_0000);
        step();
        drain(32'h4200_0000, -1, 0, 10);
        present(0, 32'h4300_0000);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_ready", 32'(readies()), 32'd7);
        chk("arst_frames", 32'(frames_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        present(0, 32'h4400_0000); present(1, 32'h4400_0000); present(2, 32'h4400_0000);
        step();
        chk("j_valid", 32'(out_valid), 32'd1);
        drain(32'h4400_0000, -1, 0, TOT);
        chk("j_frames", 32'(frames_done), 32'd1);
        chk("j_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
